// File: rtl/clock_pkg.sv
// Shared encodings, field limits and small helpers for the hour/minute/second core.
package clock_pkg;

  typedef enum logic {
    MODE_CLOCK = 1'b0,
    MODE_SETUP = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    POS_SEC = 2'd0,
    POS_MIN = 2'd1,
    POS_HR  = 2'd2
  } pos_e;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;
  localparam int unsigned HR_MAX  = 23;

  localparam int unsigned SEC_W = 6;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned HR_W  = 5;

  function automatic pos_e next_pos(input pos_e pos);
    pos_e res;
    case (pos)
      POS_SEC: res = POS_MIN;
      POS_MIN: res = POS_HR;
      default: res = POS_SEC;
    endcase
    return res;
  endfunction

  // 0 -> 12, 1..12 unchanged, 13..23 -> hour - 12.
  function automatic logic [HR_W-1:0] hr_to_12(input logic [HR_W-1:0] hr);
    logic [HR_W-1:0] res;
    if (hr == '0) begin
      res = HR_W'(12);
    end else if (hr > HR_W'(12)) begin
      res = hr - HR_W'(12);
    end else begin
      res = hr;
    end
    return res;
  endfunction

endpackage

// File: rtl/hms_time_core_if.sv
// Pulse inputs and time/status outputs of the timekeeping core.
interface hms_time_core_if;
  logic       i_mode_pls;
  logic       i_pos_pls;
  logic       i_inc_pls;
  logic       i_dec_pls;
  logic       i_fmt_pls;
  logic [5:0] o_sec;
  logic [5:0] o_min;
  logic [4:0] o_hr;
  logic       o_pm;
  logic       o_mode;
  logic [1:0] o_position;
  logic       o_blink;
  logic       o_day_tick;

  modport master (
    output i_mode_pls, i_pos_pls, i_inc_pls, i_dec_pls, i_fmt_pls,
    input  o_sec, o_min, o_hr, o_pm, o_mode, o_position, o_blink, o_day_tick
  );

  modport slave (
    input  i_mode_pls, i_pos_pls, i_inc_pls, i_dec_pls, i_fmt_pls,
    output o_sec, o_min, o_hr, o_pm, o_mode, o_position, o_blink, o_day_tick
  );
endinterface

// File: rtl/mod_updn_cnt.sv
// Modulo (Max+1) up/down counter; wrap flags an increment from Max back to 0.
module mod_updn_cnt #(
  parameter int unsigned Width = 6,
  parameter int unsigned Max   = 59
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic             dec_en,
  output logic [Width-1:0] cnt,
  output logic             wrap
);

  localparam logic [Width-1:0] MaxV = Width'(Max);

  logic [Width-1:0] cnt_q, cnt_d;
  logic             inc_only, dec_only;

  // Simultaneous inc and dec cancel out.
  assign inc_only = inc_en & ~dec_en;
  assign dec_only = dec_en & ~inc_en;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_only) begin
      cnt_d = (cnt_q == MaxV) ? '0 : cnt_q + Width'(1);
    end else if (dec_only) begin
      cnt_d = (cnt_q == '0) ? MaxV : cnt_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign wrap = inc_only & (cnt_q == MaxV);

endmodule

// File: rtl/hms_time_core.sv
// Single-clock hh:mm:ss timekeeper with setup editing, 12/24-hour output and edit blink.
module hms_time_core
  import clock_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter bit          HR_FMT12_DEF = 1'b0
) (
  input logic             clk,
  input logic             rst_n,
  hms_time_core_if.slave  bus
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] BLINK_MAX = PW'(CLK_HZ / 4 - 1);

  mode_e          mode_q, mode_d;
  pos_e           pos_q, pos_d;
  logic [PW-1:0]  presc_q, presc_d;
  logic [PW-1:0]  blink_cnt_q, blink_cnt_d;
  logic           blink_q, blink_d;
  logic           fmt12_q, fmt12_d;
  logic           day_tick_q, day_tick_d;

  logic           in_clock, tick, edit_en;
  logic           sec_inc, sec_dec, min_inc, min_dec, hr_inc, hr_dec;
  logic           sec_wrap, min_wrap, hr_wrap;
  logic [SEC_W-1:0] sec_cnt;
  logic [MIN_W-1:0] min_cnt;
  logic [HR_W-1:0]  hr_cnt;

  assign in_clock = (mode_q == MODE_CLOCK);
  assign tick     = in_clock && (presc_q == PRESC_MAX);
  // A mode pulse suppresses any edit in the same cycle.
  assign edit_en  = !in_clock && !bus.i_mode_pls;

  // Mode / position FSM.
  always_comb begin
    mode_d = mode_q;
    pos_d  = pos_q;
    unique case (mode_q)
      MODE_CLOCK: begin
        if (bus.i_mode_pls) begin
          mode_d = MODE_SETUP;
          pos_d  = POS_SEC;
        end
      end
      MODE_SETUP: begin
        if (bus.i_mode_pls) begin
          mode_d = MODE_CLOCK;
        end else if (bus.i_pos_pls) begin
          pos_d = next_pos(pos_q);
        end
      end
      default: mode_d = MODE_CLOCK;
    endcase
  end

  // Prescaler held at 0 throughout setup so leaving it gives a full second.
  always_comb begin
    presc_d = presc_q;
    if (!in_clock || bus.i_mode_pls || tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  // Edits hit only the selected field; carries exist only in clock mode.
  always_comb begin
    sec_inc = tick || (edit_en && bus.i_inc_pls && pos_q == POS_SEC);
    sec_dec = edit_en && bus.i_dec_pls && pos_q == POS_SEC;
    min_inc = (in_clock && sec_wrap) || (edit_en && bus.i_inc_pls && pos_q == POS_MIN);
    min_dec = edit_en && bus.i_dec_pls && pos_q == POS_MIN;
    hr_inc  = (in_clock && min_wrap) || (edit_en && bus.i_inc_pls && pos_q == POS_HR);
    hr_dec  = edit_en && bus.i_dec_pls && pos_q == POS_HR;
    day_tick_d = in_clock && hr_wrap;
  end

  // Blink forced visible outside setup, on any mode change and on any edit.
  always_comb begin
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;
    if (in_clock || bus.i_mode_pls || bus.i_inc_pls || bus.i_dec_pls) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_d     = ~blink_q;
      blink_cnt_d = '0;
    end else begin
      blink_cnt_d = blink_cnt_q + PW'(1);
    end
  end

  assign fmt12_d = fmt12_q ^ bus.i_fmt_pls;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_CLOCK;
      pos_q       <= POS_SEC;
      presc_q     <= '0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
      fmt12_q     <= HR_FMT12_DEF;
      day_tick_q  <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      pos_q       <= pos_d;
      presc_q     <= presc_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
      fmt12_q     <= fmt12_d;
      day_tick_q  <= day_tick_d;
    end
  end

  mod_updn_cnt #(.Width(SEC_W), .Max(SEC_MAX)) u_sec (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (sec_inc),
    .dec_en (sec_dec),
    .cnt    (sec_cnt),
    .wrap   (sec_wrap)
  );

  mod_updn_cnt #(.Width(MIN_W), .Max(MIN_MAX)) u_min (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (min_inc),
    .dec_en (min_dec),
    .cnt    (min_cnt),
    .wrap   (min_wrap)
  );

  mod_updn_cnt #(.Width(HR_W), .Max(HR_MAX)) u_hr (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (hr_inc),
    .dec_en (hr_dec),
    .cnt    (hr_cnt),
    .wrap   (hr_wrap)
  );

  assign bus.o_sec      = sec_cnt;
  assign bus.o_min      = min_cnt;
  assign bus.o_hr       = fmt12_q ? hr_to_12(hr_cnt) : hr_cnt;
  assign bus.o_pm       = fmt12_q && (hr_cnt >= HR_W'(12));
  assign bus.o_mode     = mode_q;
  assign bus.o_position = pos_q;
  assign bus.o_blink    = blink_q;
  assign bus.o_day_tick = day_tick_q;

endmodule

// File: tb/tb_hms_time_core.sv
// Scoreboard bench for hms_time_core at CLK_HZ = 8: expectations queued with stimulus.
module tb_hms_time_core;

  localparam int SelSec = 0, SelMin = 1, SelHr = 2, SelPm = 3;
  localparam int SelMode = 4, SelPos = 5, SelBlink = 6, SelDay = 7;

  typedef struct {
    string tag;
    int    sel;
    int    val;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  exp_t sb[$];

  hms_time_core_if bus ();

  hms_time_core #(
    .CLK_HZ       (8),
    .HR_FMT12_DEF (1'b0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int get_obs(input int sel);
    case (sel)
      SelSec:   return int'(bus.o_sec);
      SelMin:   return int'(bus.o_min);
      SelHr:    return int'(bus.o_hr);
      SelPm:    return int'(bus.o_pm);
      SelMode:  return int'(bus.o_mode);
      SelPos:   return int'(bus.o_position);
      SelBlink: return int'(bus.o_blink);
      default:  return int'(bus.o_day_tick);
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sel, input int val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq(e.tag, get_obs(e.sel), e.val);
    end
  endtask

  task automatic push_reset_exp(input string pfx);
    push_exp({pfx, "_sec"}, SelSec, 0);
    push_exp({pfx, "_min"}, SelMin, 0);
    push_exp({pfx, "_hr"}, SelHr, 0);
    push_exp({pfx, "_pm"}, SelPm, 0);
    push_exp({pfx, "_mode"}, SelMode, 0);
    push_exp({pfx, "_pos"}, SelPos, 0);
    push_exp({pfx, "_blink"}, SelBlink, 1);
    push_exp({pfx, "_day"}, SelDay, 0);
  endtask

  task automatic clear_inputs();
    bus.i_mode_pls = 1'b0;
    bus.i_pos_pls  = 1'b0;
    bus.i_inc_pls  = 1'b0;
    bus.i_dec_pls  = 1'b0;
    bus.i_fmt_pls  = 1'b0;
  endtask

  // One-cycle pulse set; outputs checked #1 after the sampling edge.
  task automatic pulse(input bit m, input bit p, input bit i, input bit d, input bit f);
    @(negedge clk);
    bus.i_mode_pls = m;
    bus.i_pos_pls  = p;
    bus.i_inc_pls  = i;
    bus.i_dec_pls  = d;
    bus.i_fmt_pls  = f;
    @(posedge clk);
    #1;
    clear_inputs();
    drain();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    clear_inputs();
    #12;
    push_reset_exp("reset");
    drain();
    @(negedge clk);
    rst_n = 1'b1;

    // First second after CLK_HZ edges.
    push_exp("tick_pre_sec", SelSec, 0);
    step(7);
    push_exp("tick_sec", SelSec, 1);
    step(1);

    // Setup entry and wrap editing; preload 23:59:59.
    push_exp("enter_mode", SelMode, 1);
    push_exp("enter_pos", SelPos, 0);
    push_exp("enter_blink", SelBlink, 1);
    push_exp("enter_sec", SelSec, 1);
    pulse(1, 0, 0, 0, 0);
    push_exp("dec_sec_1", SelSec, 0);
    pulse(0, 0, 0, 1, 0);
    push_exp("dec_sec_wrap", SelSec, 59);
    pulse(0, 0, 0, 1, 0);
    push_exp("pos_min", SelPos, 1);
    pulse(0, 1, 0, 0, 0);
    push_exp("dec_min_wrap", SelMin, 59);
    push_exp("dec_min_sec", SelSec, 59);
    pulse(0, 0, 0, 1, 0);
    push_exp("pos_hr", SelPos, 2);
    pulse(0, 1, 0, 0, 0);
    push_exp("dec_hr_wrap", SelHr, 23);
    pulse(0, 0, 0, 1, 0);
    push_exp("inc_hr_wrap", SelHr, 0);
    push_exp("inc_hr_min", SelMin, 59);
    push_exp("inc_hr_day", SelDay, 0);
    pulse(0, 0, 1, 0, 0);
    push_exp("dec_hr_back", SelHr, 23);
    pulse(0, 0, 0, 1, 0);
    push_exp("exit_mode", SelMode, 0);
    push_exp("exit_blink", SelBlink, 1);
    pulse(1, 0, 0, 0, 0);

    // Rollover a full second after leaving setup.
    push_exp("roll_pre_sec", SelSec, 59);
    push_exp("roll_pre_hr", SelHr, 23);
    push_exp("roll_pre_day", SelDay, 0);
    step(7);
    push_exp("roll_sec", SelSec, 0);
    push_exp("roll_min", SelMin, 0);
    push_exp("roll_hr", SelHr, 0);
    push_exp("roll_day", SelDay, 1);
    step(1);
    push_exp("roll_day_end", SelDay, 0);
    push_exp("roll_sec_hold", SelSec, 0);
    step(1);

    // 12-hour mapping.
    push_exp("fmt_enter_pos", SelPos, 0);
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    push_exp("fmt_pos_hr", SelPos, 2);
    pulse(0, 1, 0, 0, 0);
    push_exp("fmt_h0_hr", SelHr, 12);
    push_exp("fmt_h0_pm", SelPm, 0);
    pulse(0, 0, 0, 0, 1);
    for (int k = 0; k < 11; k++) pulse(0, 0, 1, 0, 0);
    push_exp("fmt_h12_hr", SelHr, 12);
    push_exp("fmt_h12_pm", SelPm, 1);
    pulse(0, 0, 1, 0, 0);
    push_exp("fmt_h13_hr", SelHr, 1);
    push_exp("fmt_h13_pm", SelPm, 1);
    pulse(0, 0, 1, 0, 0);
    push_exp("fmt24_hr", SelHr, 13);
    push_exp("fmt24_pm", SelPm, 0);
    pulse(0, 0, 0, 0, 1);

    // Simultaneous pulses.
    push_exp("incdec_hr", SelHr, 13);
    pulse(0, 0, 1, 1, 0);
    push_exp("modeinc_mode", SelMode, 0);
    push_exp("modeinc_hr", SelHr, 13);
    pulse(1, 0, 1, 0, 0);
    push_exp("reenter_mode", SelMode, 1);
    push_exp("reenter_pos", SelPos, 0);
    push_exp("reenter_sec", SelSec, 0);
    pulse(1, 0, 0, 0, 0);
    push_exp("posinc_sec", SelSec, 1);
    push_exp("posinc_pos", SelPos, 1);
    pulse(0, 1, 1, 0, 0);

    // Blink at CLK_HZ/4 = 2 cycles per half period.
    push_exp("blink_inc_min", SelMin, 1);
    push_exp("blink_inc", SelBlink, 1);
    pulse(0, 0, 1, 0, 0);
    push_exp("blink_a", SelBlink, 1);
    step(1);
    push_exp("blink_b", SelBlink, 0);
    step(1);
    push_exp("blink_c", SelBlink, 0);
    step(1);
    push_exp("blink_d", SelBlink, 1);
    step(1);
    push_exp("blink_e", SelBlink, 1);
    step(1);
    push_exp("blink_f", SelBlink, 0);
    step(1);
    push_exp("blink_force_inc", SelBlink, 1);
    push_exp("blink_force_min", SelMin, 2);
    pulse(0, 0, 1, 0, 0);
    push_exp("blink_exit", SelBlink, 1);
    push_exp("blink_exit_mode", SelMode, 0);
    pulse(1, 0, 0, 0, 0);
    push_exp("blink_clock_hold", SelBlink, 1);
    step(3);

    // Reset mid-edit at HR with hr = 5.
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    pulse(0, 1, 0, 0, 0);
    for (int k = 0; k < 7; k++) pulse(0, 0, 0, 1, 0);
    push_exp("edit_hr5", SelHr, 5);
    push_exp("edit_pos_hr", SelPos, 2);
    push_exp("edit_mode", SelMode, 1);
    pulse(0, 0, 0, 1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    push_reset_exp("midrst");
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hms_time_core.md
# hms_time_core

Parametrised single-clock-domain hour/minute/second timekeeping core with a built-in setup mode. It replaces the derived-clock counter chain: every register runs on `clk`, and one-cycle enables carry the seconds tick and the setup pulses. It sits between the debounced-switch front end and the digit-split/7-segment display path. It adds three things the derived-clock chain lacks:
- 12/24-hour output format.
- Increment and decrement editing.
- A blink strobe for the field being edited.

## Interface
- `CLK_HZ`, default 50_000_000: `clk` cycles per second; must be ≥ 4 and a multiple of 4.
- `HR_FMT12_DEF`, default 0: value of the internal format flag at reset (1 = 12-hour output).
- `clk`  in  1  system clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_mode_pls`  in  1  one-cycle pulse: toggle between CLOCK and SETUP mode.
- `i_pos_pls`  in  1  one-cycle pulse: advance the edited field (SETUP only).
- `i_inc_pls`  in  1  one-cycle pulse: increment the selected field (SETUP only).
- `i_dec_pls`  in  1  one-cycle pulse: decrement the selected field (SETUP only).
- `i_fmt_pls`  in  1  one-cycle pulse: toggle the 12/24-hour format flag (any mode).
- `o_sec`  out  6  seconds, 0..59.
- `o_min`  out  6  minutes, 0..59.
- `o_hr`  out  5  display hour: 0..23 in 24-hour format, 1..12 in 12-hour format.
- `o_pm`  out  1  1 when the internal hour is ≥ 12; forced 0 in 24-hour format.
- `o_mode`  out  1  0 = CLOCK, 1 = SETUP.
- `o_position`  out  2  0 = SEC, 1 = MIN, 2 = HR; the value 3 never appears.
- `o_blink`  out  1  1 = show the selected field, 0 = blank it.
- `o_day_tick`  out  1  one-cycle pulse on the 23:59:59 → 00:00:00 rollover.

## Operation
- **Reset values:** sec = min = hr = 0; mode = CLOCK; position = SEC; prescaler = 0; blink counter = 0; `o_blink` = 1; `o_day_tick` = 0; format flag = `HR_FMT12_DEF`.
- **Prescaler:** counts 0..CLK_HZ-1 and wraps. `tick` is asserted while the count equals CLK_HZ-1.
- **CLOCK mode, on `tick`:**
  - sec increments; 59 wraps to 0 and carries into min.
  - min carries into hr the same way; hr wraps 23 to 0.
  - The whole cascade resolves in one edge, so 23:59:59 becomes 00:00:00 in a single cycle.
  - That same edge sets `o_day_tick` for exactly one cycle.
- **Pulses ignored in CLOCK mode:** `i_pos_pls`, `i_inc_pls`, `i_dec_pls`.
- **Entering SETUP** (`i_mode_pls` while in CLOCK):
  - position is forced to SEC.
  - The prescaler is cleared and held at 0 while in SETUP, so no ticks occur.
- **SETUP editing:**
  - `i_pos_pls` cycles SEC → MIN → HR → SEC.
  - `i_inc_pls` / `i_dec_pls` change only the selected field, modulo its range (59 + 1 → 0, 0 − 1 → 59; hr uses 23 and 0).
  - Edits never carry into other fields and never raise `o_day_tick`.
- **Leaving SETUP** (`i_mode_pls` while in SETUP): the prescaler restarts from 0, so the first tick comes a full CLK_HZ cycles later.
- **Same-cycle priority:**
  - `i_mode_pls` wins over pos/inc/dec, which are ignored that cycle.
  - inc and dec together means no change.
  - pos together with inc/dec: the edit applies to the old position, then the position advances.
- **Format:** `i_fmt_pls` toggles the flag at any time and never changes the stored hour. In 12-hour format the display hour maps as 0 → 12, 1..12 unchanged, 13..23 → hour − 12.
- **Blink:**
  - In SETUP, a counter of CLK_HZ/4 cycles toggles `o_blink`, giving a 2 Hz square wave.
  - `o_blink` is forced to 1, and the counter cleared, on SETUP entry, in CLOCK mode, and on any inc/dec pulse so the edited value stays visible.
- **Width rules:** all field arithmetic uses explicit wrap compares; no reliance on natural overflow.

## Timing
- Every output is registered. The display hour and `o_pm` are computed from registered state plus the format flag, with no added latency.
- Tick visibility: the prescaler reads CLK_HZ-1 in cycle N, and the new seconds value appears in cycle N+1.
- The first seconds increment after reset release appears CLK_HZ cycles after the first active edge.
- Pulse response: a pulse sampled at edge K is reflected on the outputs from cycle K+1.
- Reset asserted mid-operation, including mid-edit, immediately returns all state to the reset values.

## Structure
- **Shared package `clock_pkg`:**
  - Mode encodings: `MODE_CLOCK`, `MODE_SETUP`.
  - Position encodings: `POS_SEC`, `POS_MIN`, `POS_HR`.
  - Field maxima: `SEC_MAX` = 59, `MIN_MAX` = 59, `HR_MAX` = 23.
- **Sub-module `mod_updn_cnt`**, instantiated three times:
  - Parameters: width and max.
  - Inputs: `inc_en`, `dec_en`.
  - Outputs: `cnt`, and `wrap` (asserted on an increment from max to 0).
- The prescaler, blink counter, mode/position FSM and 12-hour mapping stay in the top module.

## Test plan
- **Tick and rollover** (CLK_HZ = 8, reset, run 8 cycles): sec = 1 at cycle 8. Preload 23:59:59 via setup, exit, wait 8 cycles: 00:00:00 and `o_day_tick` high for exactly one cycle.
- **Setup wrap:** enter SETUP, dec at sec = 0 gives 59; pos ×2 then inc at hr = 23 gives hr = 0, with min unchanged and no `o_day_tick`.
- **12-hour mapping:** set hr = 0, 12 and 13, then toggle format: `o_hr`/`o_pm` read 12/0, 12/1 and 1/1.
- **Simultaneous pulses:** inc + dec gives no change; mode + inc gives a mode toggle with the field unchanged; pos + inc increments the old field and advances position.
- **Blink** (CLK_HZ = 8, SETUP): `o_blink` toggles every 2 cycles; an inc pulse forces it to 1; exiting SETUP holds it at 1.
- **Reset mid-edit:** in SETUP at position HR with hr = 5, assert `rst_n` = 0: all outputs return to their reset values asynchronously.
